// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit for the execute stage: a single-cycle multiply,
// a DIV_ITER-cycle restoring divide, and stall/done handshaking to the pipeline.

`ifndef MUL
`define MUL    5'd16
`endif
`ifndef MULH
`define MULH   5'd17
`endif
`ifndef MULHSU
`define MULHSU 5'd18
`endif
`ifndef MULHU
`define MULHU  5'd19
`endif
`ifndef DIV
`define DIV    5'd20
`endif
`ifndef DIVU
`define DIVU   5'd21
`endif
`ifndef REM
`define REM    5'd22
`endif
`ifndef REMU
`define REMU   5'd23
`endif

module muldiv_sequencer #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alucode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned     CntW     = $clog2(DIV_ITER) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(DIV_ITER - 1);
    localparam logic [CntW-1:0] MaxCnt   = CntW'(DIV_ITER);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      op_q;
    logic [31:0]     a_q, b_q;
    logic [31:0]     quot_q, rem_q, dvs_q;
    logic [CntW-1:0] cnt_q;
    logic            neg_quot_q, neg_rem_q;
    logic [31:0]     result_q;

    logic        valid_op, is_mul, is_signed_div, is_div_quot;
    logic        accept, overflow, special, last_iter;
    logic [31:0] special_res, abs_a, abs_b;

    always_comb begin
        valid_op = 1'b0;
        is_mul   = 1'b0;
        case (alucode)
            `MUL, `MULH, `MULHSU, `MULHU: begin
                valid_op = 1'b1;
                is_mul   = 1'b1;
            end
            `DIV, `DIVU, `REM, `REMU: valid_op = 1'b1;
            default: ;
        endcase
    end

    assign is_signed_div = (alucode == `DIV) || (alucode == `REM);
    assign is_div_quot   = (alucode == `DIV) || (alucode == `DIVU);
    assign accept        = (state_q == StIdle) && start && !flush && valid_op;
    assign overflow      = is_signed_div && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    assign special       = !is_mul && ((op2 == 32'h0) || overflow);
    assign abs_a         = (is_signed_div && op1[31]) ? -op1 : op1;
    assign abs_b         = (is_signed_div && op2[31]) ? -op2 : op2;
    assign last_iter     = (cnt_q == LastIter);

    // Divide-by-zero and signed overflow bypass the iteration loop entirely.
    always_comb begin
        if (op2 == 32'h0) begin
            special_res = is_div_quot ? 32'hFFFF_FFFF : op1;
        end else begin
            special_res = is_div_quot ? 32'h8000_0000 : 32'h0;
        end
    end

    // Multiply on latched operands; 33-bit extension selects signed/unsigned per op.
    logic               a_sx, b_sx;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;

    always_comb begin
        a_sx    = (op_q != `MULHU);
        b_sx    = (op_q == `MUL) || (op_q == `MULH);
        mul_a   = $signed({a_sx & a_q[31], a_q});
        mul_b   = $signed({b_sx & b_q[31], b_q});
        prod    = 64'(mul_a) * 64'(mul_b);
        mul_res = (op_q == `MUL) ? prod[31:0] : prod[63:32];
    end

    // One restoring shift-subtract step on magnitudes.
    logic [32:0] shifted, sub;
    logic        ge;
    logic [31:0] quot_nxt, rem_nxt, div_res;
    logic        unused_sub;

    always_comb begin
        shifted  = {rem_q, quot_q[31]};
        sub      = shifted - {1'b0, dvs_q};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_nxt  = ge ? sub[31:0] : shifted[31:0];
        quot_nxt = {quot_q[30:0], ge};
        if ((op_q == `DIV) || (op_q == `DIVU)) begin
            div_res = neg_quot_q ? -quot_nxt : quot_nxt;
        end else begin
            div_res = neg_rem_q ? -rem_nxt : rem_nxt;
        end
    end

    assign unused_sub = sub[32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (special) begin
                        state_d = StDone;
                    end else begin
                        state_d = is_mul ? StMul : StDiv;
                    end
                end
            end
            StMul:   state_d = flush ? StIdle : StDone;
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall  = accept || (state_q == StMul) || (state_q == StDiv);
        done   = (state_q == StDone);
        result = result_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= 5'h0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            quot_q     <= 32'h0;
            rem_q      <= 32'h0;
            dvs_q      <= 32'h0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 32'h0;
        end else if (accept) begin
            op_q       <= alucode;
            a_q        <= op1;
            b_q        <= op2;
            quot_q     <= abs_a;
            rem_q      <= 32'h0;
            dvs_q      <= abs_b;
            cnt_q      <= '0;
            neg_quot_q <= is_signed_div && (op1[31] ^ op2[31]);
            neg_rem_q  <= is_signed_div && op1[31];
            if (special) begin
                result_q <= special_res;
            end
        end else if (state_q == StMul && !flush) begin
            result_q <= mul_res;
        end else if (state_q == StDiv && !flush) begin
            quot_q <= quot_nxt;
            rem_q  <= rem_nxt;
            cnt_q  <= (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);
            if (last_iter) begin
                result_q <= div_res;
            end
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DIV_ITER, default 32, which is the number of divide iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: the execute stage requests an operation this cycle.
REQ-005 SHALL have port alucode, input, 5 bits: operation select using the `MUL, `MULH, `MULHSU, `MULHU, `DIV, `DIVU, `REM, `REMU defines.
REQ-006 SHALL have ports op1 and op2, input, 32 bits each: rs1 and rs2 operands.
REQ-007 SHALL have port flush, input, 1 bit: the execute stage is being flushed; abort the operation.
REQ-008 SHALL have port stall, output, 1 bit: drives the pipeline stallF/stallD and flushE requests.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse meaning result is valid.
REQ-010 SHALL have port result, output, 32 bits: the operation result.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-012 Accept SHALL be defined as: state==IDLE, start==1, flush==0, and alucode is one of the eight defines. On accept, the block latches alucode, op1 and op2.
REQ-013 A start with any other alucode, or a start outside IDLE, SHALL be ignored with no state change.
REQ-014 stall SHALL be combinational and equal to (accept condition) OR state==MUL OR state==DIV; stall SHALL be 0 in IDLE without accept and 0 in DONE.
REQ-015 Multiply timing: accept in cycle T, MUL in T+1, DONE in T+2.
REQ-016 Multiply arithmetic: compute a 64-bit product with operands extended to 33 bits. Sign handling is per op: MUL signed/signed, MULH signed/signed, MULHSU signed/unsigned, MULHU unsigned/unsigned. MUL returns bits [31:0]; the others return bits [63:32].
REQ-017 Divide/remainder: after accept, spend DIV_ITER cycles in DIV running a restoring shift-subtract on magnitudes, then go to DONE. Accept in T gives DONE in T+DIV_ITER+1.
REQ-018 Signed divide fix-up: quotient is negated if the operand signs differ; the remainder takes the sign of op1.
REQ-019 Divide by zero (op2==0): go from accept directly to DONE at T+1. DIV/DIVU return 32'hFFFFFFFF; REM/REMU return op1.
REQ-020 Signed overflow (DIV/REM with op1==32'h80000000 and op2==32'hFFFFFFFF): DONE at T+1. DIV returns 32'h80000000; REM returns 0.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-022 result SHALL hold its value from DONE until the next DONE.
REQ-023 A start in the DONE cycle SHALL be ignored; the pipeline holds no new instruction in execute then.
REQ-024 flush==1 in MUL or DIV SHALL return the block to IDLE on the next edge with no done pulse; result is unchanged.
REQ-025 flush==1 in DONE SHALL still give done=1 in that cycle, and the next state is IDLE.
REQ-026 flush and start together in IDLE SHALL not accept.
REQ-027 The iteration counter SHALL be $clog2(DIV_ITER)+1 bits wide and SHALL not wrap past DIV_ITER.
REQ-028 Operand latches SHALL be unaffected by op1/op2 changes after accept.

Reset
REQ-029 reset low SHALL asynchronously force: state=IDLE, stall=0, done=0, result=0, iteration counter=0, internal quotient/remainder registers=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-031 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-032 MUL: op1=7, op2=-3 (32'hFFFFFFFD), start at T -> stall=1 at T and T+1; done=1 and result=32'hFFFFFFEB at T+2; stall=0 at T+2.
REQ-033 MULHU: op1=op2=32'hFFFFFFFF -> result=32'hFFFFFFFE at T+2. MULHSU: op1=-1, op2=2 -> result=32'hFFFFFFFF.
REQ-034 DIV: op1=-7, op2=2 -> done at T+33 with result=32'hFFFFFFFD. REM with the same operands -> 32'hFFFFFFFF. stall high T..T+32.
REQ-035 DIVU with op2=0, op1=5 -> done at T+1, result=32'hFFFFFFFF. REMU with the same operands -> result=5. DIV 32'h80000000 / -1 -> result=32'h80000000 at T+1.
REQ-036 Start DIVU, assert flush at T+10 -> state=IDLE at T+11, no done, result unchanged; a new MUL started at T+12 completes at T+14.
REQ-037 Pull reset low during the DIV state at T+5 -> stall=0, done=0 and result=0 immediately, with no done pulse afterwards.
